// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq: sequential divider back end for the MIPS DIV/DIVU path.
//
// Takes a divide request, forms operand magnitudes for the external align
// stage, waits ALIGN_WAIT cycles for the aligned divisor, then does one
// restoring shift-subtract iteration per cycle and applies the MIPS sign
// rules. The quotient is presented on lo and the remainder on hi.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request strobe, sampled only while idle
//   sgn        1 = DIV (signed), 0 = DIVU
//   dva, dvb   dividend / divisor
//   al_rst     one-cycle load strobe to the align stage
//   al_a, al_b |dividend|, |divisor| to the align stage, held while busy
//   al_shiftb  aligned divisor returned by the align stage
//   busy       operation in progress
//   done       one-cycle pulse, hi/lo valid from this cycle
//   hi, lo     remainder / quotient, held until the next accepted start
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int unsigned ALIGN_WAIT = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] dva,
    input  logic [31:0] dvb,
    output logic        al_rst,
    output logic [31:0] al_a,
    output logic [31:0] al_b,
    input  logic [31:0] al_shiftb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_sgn;
    logic [31:0] r_dva;
    logic        r_dvb_neg;
    logic        r_dbz;
    logic [31:0] r_ma;
    logic [31:0] r_mb;
    logic [31:0] r_d;
    logic [31:0] r_r;
    logic [31:0] r_q;
    logic [31:0] r_cnt;
    logic        r_al_rst;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Magnitudes of the incoming operands; -0x80000000 wraps to itself,
    // which is the correct unsigned magnitude.
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic        w_ge;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_ma = (sgn && dva[31]) ? (32'd0 - dva) : dva;
    assign w_mb = (sgn && dvb[31]) ? (32'd0 - dvb) : dvb;
    assign w_ge = (r_r >= r_d);

    // Sign fix-up. On divide-by-zero the quotient stays all ones and the
    // remainder is the original dividend (re-negating |dva| restores it).
    assign w_q_fix = (r_sgn && !r_dbz && (r_dva[31] ^ r_dvb_neg)) ? (32'd0 - r_q) : r_q;
    assign w_r_fix = r_dbz                 ? r_dva :
                     (r_sgn && r_dva[31])  ? (32'd0 - r_r) : r_r;

    // NOTE: every register, result outputs included, is cleared by the
    // asynchronous reset so that no partial result survives an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sgn     <= 1'b0;
            r_dva     <= '0;
            r_dvb_neg <= 1'b0;
            r_dbz     <= 1'b0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_d       <= '0;
            r_r       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_al_rst  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the values held at the start of the cycle.
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sgn     <= sgn;
                        r_dva     <= dva;
                        r_dvb_neg <= dvb[31];
                        r_ma      <= w_ma;
                        r_mb      <= w_mb;
                        r_busy    <= 1'b1;
                        if (w_mb == 32'd0) begin
                            r_q     <= 32'hFFFF_FFFF;
                            r_r     <= w_ma;
                            r_dbz   <= 1'b1;
                            r_state <= S_FIX;
                        end else if (w_ma < w_mb) begin
                            r_q     <= '0;
                            r_r     <= w_ma;
                            r_dbz   <= 1'b0;
                            r_state <= S_FIX;
                        end else begin
                            r_dbz    <= 1'b0;
                            r_al_rst <= 1'b1;
                            r_cnt    <= 32'd1;
                            r_state  <= S_ALIGN;
                        end
                    end
                end

                S_ALIGN: begin
                    r_al_rst <= 1'b0;
                    if (r_cnt >= ALIGN_WAIT) begin
                        r_d     <= al_shiftb;
                        r_r     <= r_ma;
                        r_q     <= '0;
                        r_cnt   <= 32'd1;
                        r_state <= S_DIV;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                S_DIV: begin
                    if (w_ge) begin
                        r_r <= r_r - r_d;
                    end
                    r_q <= {r_q[30:0], w_ge};
                    // Stop once the divisor has been walked back to |dvb|;
                    // the iteration cap guards against a bad align result.
                    if (r_d == r_mb || r_cnt >= 32'd32) begin
                        r_state <= S_FIX;
                    end else begin
                        r_d   <= r_d >> 1;
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                S_FIX: begin
                    r_lo    <= w_q_fix;
                    r_hi    <= w_r_fix;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign al_rst = r_al_rst;
    assign al_a   = r_ma;
    assign al_b   = r_mb;
    assign busy   = r_busy;
    assign done   = r_done;
    assign hi     = r_hi;
    assign lo     = r_lo;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq: directed self-checking bench for div_seq (ALIGN_WAIT = 18).
// The align stage is stood in for by the bench, which drives a hand-computed
// aligned divisor for each request.
// -----------------------------------------------------------------------------
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] dva;
    logic [31:0] dvb;
    logic        al_rst;
    logic [31:0] al_a;
    logic [31:0] al_b;
    logic [31:0] al_shiftb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    div_seq #(.ALIGN_WAIT(18)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sgn       (sgn),
        .dva       (dva),
        .dvb       (dvb),
        .al_rst    (al_rst),
        .al_a      (al_a),
        .al_b      (al_b),
        .al_shiftb (al_shiftb),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request. Latency is counted in cycles after the accepting edge T,
    // sampling 1 ns after each rising edge.
    task automatic run(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] shb,
                       input logic [31:0] ma, input logic [31:0] mb,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input int exp_lat, input bit normal, input bit repulse);
        int cyc;
        int n_alrst;
        int n_done;
        @(negedge clk);
        sgn = s; dva = a; dvb = b; al_shiftb = shb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        check({tag, " busy@T+1"}, 32'(busy), 32'd1);
        check({tag, " al_rst@T+1"}, 32'(al_rst), 32'(normal));
        check({tag, " al_a"}, al_a, ma);
        check({tag, " al_b"}, al_b, mb);
        n_alrst = int'(al_rst);
        n_done  = int'(done);
        while (!done && cyc < 400) begin
            if (repulse && cyc == 5) begin
                start = 1'b1; sgn = 1'b0; dva = 32'd50; dvb = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            n_alrst += int'(al_rst);
            n_done  += int'(done);
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " al_rst pulses"}, 32'(n_alrst), 32'(normal));
        check({tag, " al_a held"}, al_a, ma);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_done += int'(done);
        end
        check({tag, " done pulses"}, 32'(n_done), 32'd1);
        check({tag, " lo held"}, lo, exp_lo);
        check({tag, " hi held"}, hi, exp_hi);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0;
        dva = '0; dvb = '0; al_shiftb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset al_rst", 32'(al_rst), 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset al_a", al_a, 32'd0);
        check("reset al_b", al_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   tag          sgn  dva           dvb           shiftb        ma            mb            lo            hi            lat nrm rep
        run("divu 100/7",  0, 32'd100,      32'd7,        32'd56,       32'd100,      32'd7,        32'd14,       32'd2,        24, 1, 0);
        run("div -100/7",  1, 32'hFFFFFF9C, 32'd7,        32'd56,       32'd100,      32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 24, 1, 0);
        run("div 100/-7",  1, 32'd100,      32'hFFFFFFF9, 32'd56,       32'd100,      32'd7,        32'hFFFFFFF2, 32'd2,        24, 1, 0);
        run("divu 5/0",    0, 32'd5,        32'd0,        32'd0,        32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,         2, 0, 0);
        run("div -5/0",    1, 32'hFFFFFFFB, 32'd0,        32'd0,        32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB,  2, 0, 0);
        run("divu 3/9",    0, 32'd3,        32'd9,        32'd9,        32'd3,        32'd9,        32'd0,        32'd3,         2, 0, 0);
        run("div ovf",     1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        52, 1, 0);
        run("divu max/1",  0, 32'hFFFFFFFF, 32'd1,        32'h80000000, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        52, 1, 0);
        run("repulse",     0, 32'd100,      32'd7,        32'd56,       32'd100,      32'd7,        32'd14,       32'd2,        24, 1, 1);

        // Asynchronous reset in the middle of the DIV phase.
        @(negedge clk);
        sgn = 1'b0; dva = 32'd200; dvb = 32'd3; al_shiftb = 32'd192; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid busy before rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst lo", lo, 32'd0);
        check("async rst hi", hi, 32'd0);
        check("async rst al_a", al_a, 32'd0);
        check("async rst al_b", al_b, 32'd0);
        check("async rst done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run("after rst",   0, 32'd100,      32'd7,        32'd56,       32'd100,      32'd7,        32'd14,       32'd2,        24, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential divider back end for the MIPS DIV/DIVU path. It accepts a divide request from the execute stage, forms operand magnitudes, and launches the `align` stage. After a fixed settling window it captures the aligned divisor and performs one restoring shift-subtract iteration per cycle. It then applies the MIPS sign rules and presents the quotient on `lo` and the remainder on `hi`.

## Interface
- `ALIGN_WAIT`, default 18: cycles from `al_rst` assertion to capture of `al_shiftb`; must be ≥ 18 for the current `align` stage.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, **asynchronous, active-low**.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `sgn`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start`.
- `dva`  in  32  dividend; sampled with `start`.
- `dvb`  in  32  divisor; sampled with `start`.
- `al_rst`  out  1  load strobe to `align` (its `alrst`); registered.
- `al_a`  out  32  |dividend| to `align` (its `ala`); held stable while `busy`.
- `al_b`  out  32  |divisor| to `align` (its `alb`); held stable while `busy`.
- `al_shiftb`  in  32  aligned divisor from `align` (its `shiftb`).
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid from this cycle.
- `hi`  out  32  remainder; held until the next accepted `start`.
- `lo`  out  32  quotient; held until the next accepted `start`.

## Operation
- States: IDLE, ALIGN, DIV, FIX, DONE.
- **Reset (`rst_n`=0, any time, including mid-operation):** state→IDLE, all registers cleared. Outputs `busy`, `done`, `al_rst`, `hi`, `lo`, `al_a`, `al_b` are 0. No partial result survives.
- **IDLE, `start`=1:**
  - Latch `sgn`, `dva`, `dvb`.
  - Magnitudes: `ma` = (`sgn` & `dva`[31]) ? −`dva` : `dva`; `mb` likewise for `dvb`. Both are 32-bit unsigned; −0x80000000 = 0x80000000.
  - Drive `al_a`=`ma` and `al_b`=`mb`.
  - If `mb`=0: q=0xFFFFFFFF, r=`ma`, go to FIX, div-by-zero flag set.
  - Else if `ma` < `mb`: q=0, r=`ma`, go to FIX.
  - Else: go to ALIGN.
- **ALIGN:**
  - `al_rst`=1 for exactly the first ALIGN cycle; the counter runs to ALIGN_WAIT.
  - On the final count, latch d=`al_shiftb`, set r=`ma` and q=0, go to DIV.
- **DIV, one iteration per cycle:**
  - If r ≥ d: r←r−d and q←{q[30:0],1}. Otherwise q←{q[30:0],0}.
  - If d = `mb` after this comparison: go to FIX. Otherwise d←d>>1.
  - Safety cap: at most 32 iterations, then force FIX.
- **FIX:** a single cycle.
  - Signed case, no div-by-zero:
    - Negate q when `dva`[31]≠`dvb`[31].
    - Negate r when `dva`[31]=1.
  - Div-by-zero: q is not negated; r is negated back to the original `dva`.
  - Register the results into `lo`/`hi`, go to DONE.
- **DONE:** `done`=1 and `busy`=0, then return to IDLE. A `start` in DONE is ignored.
- `start` while `busy`=1 is ignored, with no queueing.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: `lo`=0x80000000, `hi`=0. No trap.

## Timing
- Accepting `start` at edge T sets `busy`=1 from T+1.
- Normal path, with k = log2(`al_shiftb`/`mb`) (k+1 DIV cycles):
  - ALIGN occupies T+1 … T+ALIGN_WAIT.
  - DIV runs k+1 cycles, then FIX takes 1 cycle.
  - `done` is high in cycle T+ALIGN_WAIT+k+3.
- Shortcut paths (`mb`=0 or `ma`<`mb`): FIX at T+1, `done` at T+2.
- `al_rst` is high only in cycle T+1; it is never asserted outside ALIGN.
- `hi`/`lo` change only in the FIX→DONE transition or on reset.

## Test plan
- DIVU 100/7, ALIGN_WAIT=18: `al_shiftb`=56, 4 DIV cycles. `done` at T+24, `lo`=14, `hi`=2.
- DIV −100/7: `lo`=0xFFFFFFF2 (−14), `hi`=0xFFFFFFFE (−2). DIV 100/−7 gives `lo`=−14, `hi`=2.
- DIVU 5/0 gives `lo`=0xFFFFFFFF, `hi`=5, `done` at T+2, `al_rst` never pulsed. DIVU 3/9 gives `lo`=0, `hi`=3 at T+2.
- DIV 0x80000000/0xFFFFFFFF: `lo`=0x80000000, `hi`=0. DIVU 0xFFFFFFFF/1: `lo`=0xFFFFFFFF, `hi`=0, 32 DIV cycles.
- `start` re-pulsed with new operands while `busy`: the result matches the first request only, and a single `done` is seen.
- `rst_n` low for 1 cycle mid-DIV: outputs are 0 immediately (asynchronous). A following DIVU 100/7 completes correctly.
